// File: rtl/fifo_reader.sv
`timescale 1ns/1ps
// fifo_reader: drains a synchronous FIFO (one-cycle read latency) into a
// two-entry in-order skid buffer with a valid/ready output and a word counter.
// Ports: clk, rst (sync, active-high); en gates new reads;
//   fifo_read/fifo_data_out/fifo_empty connect to the FIFO read port;
//   out_valid/out_ready/out_data form the downstream handshake;
//   words_out counts delivered words; idle flags a fully drained path;
//   seq_err is a sticky sequence-check flag.
// Option: define FIFO_READER_SEQCHK_EN to check that popped words increment
//   by one; without it seq_err is tied to 0.
module fifo_reader #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             fifo_read,
   input  logic [WIDTH-1:0] fifo_data_out,
   input  logic             fifo_empty,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] words_out,
   output logic             idle,
   output logic             seq_err
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

   state_e           state_q, state_d;
   logic             pend_q, pend_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] words_q, words_d;

   logic       pop;
   logic       cap;
   logic [1:0] cnt;
   logic [2:0] occ;

   assign out_valid = ~rst & (state_q != EMPTY);
   assign out_data  = head_q;
   assign words_out = words_q;
   assign pop       = out_valid & out_ready;
   assign cap       = pend_q;

   always_comb begin
      cnt = 2'd0;
      unique case (state_q)
         EMPTY:   cnt = 2'd0;
         ONE:     cnt = 2'd1;
         TWO:     cnt = 2'd2;
         default: cnt = 2'd0;
      endcase
   end

   // occupancy after this edge if no new read; pop implies cnt >= 1
   assign occ = {1'b0, cnt} + {2'b00, pend_q} - {2'b00, pop};

   assign fifo_read = ~rst & en & ~fifo_empty & (occ < 3'd2);
   assign pend_d    = fifo_read;
   assign words_d   = words_q + CNT_W'(pop);
   assign idle      = (state_q == EMPTY) & ~pend_q & fifo_empty;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      unique case (state_q)
         EMPTY: begin
            if (cap) begin
               head_d  = fifo_data_out;
               state_d = ONE;
            end
         end
         ONE: begin
            if (cap && pop) begin
               head_d = fifo_data_out;
            end else if (cap) begin
               tail_d  = fifo_data_out;
               state_d = TWO;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // capture without pop cannot occur here: reads are throttled
            if (pop) begin
               head_d = tail_q;
               if (cap) begin
                  tail_d = fifo_data_out;
               end else begin
                  state_d = ONE;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         pend_q  <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         words_q <= words_d;
      end
   end

`ifdef FIFO_READER_SEQCHK_EN
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             base_q, base_d;
   logic             err_q, err_d;

   // first pop after reset only loads the baseline
   assign prev_d = pop ? head_q : prev_q;
   assign base_d = base_q | pop;
   assign err_d  = err_q
                 | (pop & base_q & (head_q != prev_q + WIDTH'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
         base_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         prev_q <= prev_d;
         base_q <= base_d;
         err_q  <= err_d;
      end
   end

   assign seq_err = err_q;
`else
   assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
`timescale 1ns/1ps
// tb_fifo_reader: directed bench with a sync FIFO model and a scoreboard
// of expected output words.
module tb_fifo_reader;
   localparam int W  = 16;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          out_ready = 1'b0;
   logic          fifo_read;
   logic [W-1:0]  fifo_data_out = '0;
   logic          fifo_empty;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic [CW-1:0] words_out;
   logic          idle;
   logic          seq_err;

   fifo_reader #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .en(en),
      .fifo_read(fifo_read), .fifo_data_out(fifo_data_out),
      .fifo_empty(fifo_empty), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data),
      .words_out(words_out), .idle(idle), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   // synchronous FIFO model: data appears the cycle after the read
   logic [W-1:0] mem [0:255];
   logic [7:0]   wr_ptr = 8'd0;
   logic [7:0]   rd_ptr = 8'd0;
   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (fifo_read && !fifo_empty) begin
         fifo_data_out <= mem[rd_ptr];
         rd_ptr        <= rd_ptr + 8'd1;
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_cnt, valid_cnt, first_rd, first_v, last_v, remaining;
   logic         hold;
   logic [W-1:0] held;
   logic [W-1:0] exp_q[$];
   logic         exp_se;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clr_stats();
      rd_cnt = 0; valid_cnt = 0;
      first_rd = -1; first_v = -1; last_v = -1;
      hold = 1'b0;
   endtask

   // sample 1ns after the inputs change, then advance to next negedge
   task automatic tick();
      #1;
      if (!rst) begin
         if (fifo_read) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            chk("rd_when_empty", {31'd0, fifo_empty}, 32'd0);
         end
         if (out_valid) begin
            valid_cnt++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
         end
         if (hold && out_valid) chk("hold_stable", {16'd0, out_data}, {16'd0, held});
         hold = out_valid && !out_ready;
         held = out_data;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
            else chk("sb_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
         end
      end else begin
         hold = 1'b0;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic push(input logic [W-1:0] v);
      mem[wr_ptr] = v;
      wr_ptr = wr_ptr + 8'd1;
      exp_q.push_back(v);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; out_ready = 1'b0;
      wr_ptr = rd_ptr;
      exp_q.delete();
      tick();
      tick();
      rst = 1'b0;
      clr_stats();
   endtask

   initial begin
`ifdef FIFO_READER_SEQCHK_EN
      exp_se = 1'b1;
`else
      exp_se = 1'b0;
`endif
      clr_stats();

      // reset state
      do_reset();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_read", {31'd0, fifo_read}, 32'd0);
      chk("rst_words", {16'd0, words_out}, 32'd0);
      chk("rst_data", {16'd0, out_data}, 32'd0);
      chk("rst_idle", {31'd0, idle}, 32'd1);
      chk("rst_seqerr", {31'd0, seq_err}, 32'd0);

      // single word
      push(16'd7);
      out_ready = 1'b1; en = 1'b1;
      repeat (6) tick();
      chk("one_rdcnt", rd_cnt, 32'd1);
      chk("one_vcnt", valid_cnt, 32'd1);
      chk("one_lat", first_v - first_rd, 32'd2);
      chk("one_words", {16'd0, words_out}, 32'd1);
      chk("one_idle", {31'd0, idle}, 32'd1);
      chk("one_sb", exp_q.size(), 32'd0);

      // streaming 0..15
      do_reset();
      for (int i = 0; i < 16; i++) push(W'(i));
      out_ready = 1'b1; en = 1'b1;
      repeat (25) tick();
      chk("str_vcnt", valid_cnt, 32'd16);
      chk("str_span", last_v - first_v, 32'd15);
      chk("str_lat", first_v - first_rd, 32'd2);
      chk("str_rdcnt", rd_cnt, 32'd16);
      chk("str_words", {16'd0, words_out}, 32'd16);
      chk("str_idle", {31'd0, idle}, 32'd1);
      chk("str_sb", exp_q.size(), 32'd0);

      // backpressure then release
      do_reset();
      for (int i = 0; i < 16; i++) push(W'(i));
      en = 1'b1; out_ready = 1'b0;
      repeat (10) tick();
      chk("bp_rdcnt", rd_cnt, 32'd2);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {16'd0, out_data}, 32'd0);
      chk("bp_words", {16'd0, words_out}, 32'd0);
      out_ready = 1'b1;
      repeat (16) tick();
      chk("bp_words16", {16'd0, words_out}, 32'd16);
      chk("bp_rd16", rd_cnt, 32'd16);
      chk("bp_drained", {31'd0, out_valid}, 32'd0);
      chk("bp_sb", exp_q.size(), 32'd0);

      // en dropped after first read
      do_reset();
      for (int i = 0; i < 4; i++) push(W'(20 + i));
      out_ready = 1'b1; en = 1'b1;
      tick();
      en = 1'b0;
      repeat (6) tick();
      chk("en_rdcnt", rd_cnt, 32'd1);
      chk("en_words", {16'd0, words_out}, 32'd1);
      chk("en_idle", {31'd0, idle}, 32'd0);
      chk("en_read", {31'd0, fifo_read}, 32'd0);
      chk("en_sb", exp_q.size(), 32'd3);

      // reset mid-stream
      do_reset();
      for (int i = 0; i < 16; i++) push(W'(100 + i));
      out_ready = 1'b1; en = 1'b1;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      chk("mid_rd_in_rst", {31'd0, fifo_read}, 32'd0);
      chk("mid_v_in_rst", {31'd0, out_valid}, 32'd0);
      exp_q.delete();
      for (logic [7:0] p = rd_ptr; p != wr_ptr; p++) exp_q.push_back(mem[p]);
      remaining = exp_q.size();
      tick();
      rst = 1'b0;
      chk("mid_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_words", {16'd0, words_out}, 32'd0);
      chk("mid_data", {16'd0, out_data}, 32'd0);
      repeat (25) tick();
      chk("mid_words_end", {16'd0, words_out}, remaining);
      chk("mid_sb", exp_q.size(), 32'd0);

      // sequence check 0,1,2,4
      do_reset();
      push(16'd0); push(16'd1); push(16'd2); push(16'd4);
      out_ready = 1'b1; en = 1'b1;
      for (int k = 0; k < 20 && words_out != 16'd3; k++) tick();
      chk("seq_wait3", {16'd0, words_out}, 32'd3);
      chk("seq_pre", {31'd0, seq_err}, 32'd0);
      repeat (6) tick();
      chk("seq_err", {31'd0, seq_err}, {31'd0, exp_se});
      push(16'd5); push(16'd6);
      repeat (6) tick();
      chk("seq_sticky", {31'd0, seq_err}, {31'd0, exp_se});
      chk("seq_words", {16'd0, words_out}, 32'd6);
      chk("seq_sb", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
